ultrasonic_ctrl: RTL and testbench
==================================

Name: ultrasonic_ctrl

Overview:
Command-execution stage directly downstream of the command decoder. Consumes its registered on/off/increase/decrease/send/receive/valid/amount outputs. Owns transducer power state, DAC drive amplitude, TX burst generation and the RX listening window. Outputs drive the DAC interface and the analog TX/RX front-end switches.

Parameters:
AMOUNT_WIDTH, 8, width of the amount field from the decoder
DAC_WIDTH, 10, DAC code width; must be >= AMOUNT_WIDTH
HALF_PERIOD, 25, clocks per tx_pulse half-cycle (>=1)
PULSE_COUNT, 8, full tx_pulse periods per burst (>=1)
RX_WINDOW, 2000, clocks rx_enable stays high per listen (>=1)
CNT_WIDTH, 16, width of the internal timing counters

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
on  in  1  decoded power-on command
off  in  1  decoded power-off command
increase  in  1  decoded amplitude increase
decrease  in  1  decoded amplitude decrease
send  in  1  decoded start-TX-burst command
receive  in  1  decoded start-RX-window command
valid  in  1  decoded word valid
amount  in  AMOUNT_WIDTH  amplitude step
dac_value  out  DAC_WIDTH  DAC code driven to the transducer
dac_update  out  1  one-cycle strobe when dac_value changes
tx_pulse  out  1  TX excitation square wave
rx_enable  out  1  receiver gate
busy  out  1  high in TX or RX
state  out  2  OFF=0, IDLE=1, TX=2, RX=3

Behaviour:
- Reset (async, rst_n low): state OFF. amp_reg, dac_value, counters = 0. dac_update, tx_pulse, rx_enable, busy = 0. pend_rx = 0. valid_q = 0.
- Command acceptance: valid_q registers valid. A command is accepted only on cmd_stb = valid & ~valid_q, i.e. the rising edge of valid. A held valid executes once. Inputs are sampled at cmd_stb. Effects are visible on outputs the next clock.
- Priority within one accepted command: off > on > (increase/decrease, then send/receive).
- off: from any state, enter OFF. This aborts TX/RX. tx_pulse, rx_enable, busy and dac_value go to 0. amp_reg is retained.
- OFF state: only on is honoured. on -> IDLE and dac_value <= amp_reg. All other bits in that word are ignored.
- IDLE, amplitude:
  - increase: amp_reg <= min(amp_reg + amount, 2^DAC_WIDTH-1). amount is zero-extended and the sum is computed one bit wider to saturate.
  - decrease: amp_reg <= max(amp_reg - amount, 0), with underflow clamped to 0.
  - dac_value follows amp_reg in the same cycle.
  - increase and decrease are never both high (decoder guarantee). If both are high, neither is applied.
- dac_update: 1 for exactly the cycle after dac_value changes value. No strobe if saturation leaves the value unchanged.
- IDLE, send: enter TX and set pend_rx <= receive. Any amplitude change in the same word is applied first, so the burst uses the new amplitude.
- IDLE, receive without send: enter RX.
- TX:
  - tx_pulse starts at 1 on TX entry and toggles every HALF_PERIOD clocks.
  - After 2*PULSE_COUNT half-cycles: tx_pulse <= 0.
  - Exit to RX if pend_rx, otherwise to IDLE.
  - Burst length is exactly 2*HALF_PERIOD*PULSE_COUNT clocks.
- RX: rx_enable = 1 for exactly RX_WINDOW clocks, then IDLE. pend_rx is cleared on RX entry.
- TX/RX: all commands except off are ignored, including on, increase, decrease, send and receive. They are not queued.
- on while already in IDLE: no effect.
- busy = (state==TX) | (state==RX), registered with state.
- All outputs are registered.

Decomposition:
- Shared package `ultrasonic_pkg`: state encoding constants (ST_OFF, ST_IDLE, ST_TX, ST_RX) and the default timing parameter values. The decoder and this block share it.
- One natural sub-module, `burst_gen`:
  - Inputs: start, abort. Outputs: tx_pulse, done.
  - Contains the half-period and pulse counters.
  - The FSM and amplitude logic stay in the top level.

Test Plan:
- Reset then on (valid pulse 1 clk): state 0 -> 1 next clock. dac_value=0, no dac_update.
- In IDLE, increase amount=200 three times: dac_value 200, 400, 600, one dac_update each. Then increase 255 repeatedly: saturates at 1023, and a further increase gives no strobe. decrease 255 from 100 -> 0.
- valid held high 10 clocks with increase amount=5: dac_value +5 once only.
- send+receive in one word, defaults: tx_pulse high 25, low 25, repeated 8 times (400 clocks). Then rx_enable high 2000 clocks, busy high throughout, then state IDLE.
- off at clock 130 of a burst: next clock tx_pulse=0, busy=0, state OFF, dac_value=0. A following on restores dac_value to the prior amplitude.
- send during RX and increase during TX: both ignored. dac_value unchanged, no new burst after RX ends.

Source files
------------

// File: rtl/ultrasonic_pkg.sv
// Shared definitions for the ultrasonic command path: the state encoding
// seen on the state output and the default timing/width values.
package ultrasonic_pkg;

  localparam logic [1:0] ST_OFF  = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_TX   = 2'd2;
  localparam logic [1:0] ST_RX   = 2'd3;

  localparam int DEF_AMOUNT_WIDTH = 8;
  localparam int DEF_DAC_WIDTH    = 10;
  localparam int DEF_HALF_PERIOD  = 25;
  localparam int DEF_PULSE_COUNT  = 8;
  localparam int DEF_RX_WINDOW    = 2000;
  localparam int DEF_CNT_WIDTH    = 16;

  // A state counts as busy while the transducer is transmitting or listening.
  function automatic logic is_busy(input logic [1:0] st);
    return (st == ST_TX) || (st == ST_RX);
  endfunction

endpackage

// File: rtl/burst_gen.sv
// TX burst generator: a square wave of PULSE_COUNT periods, each half
// lasting HALF_PERIOD clocks, starting high on the clock after start.
// done is a combinational flag marking the final clock of the burst so
// the owner can leave TX on the same edge that drops tx_pulse.
module burst_gen
  import ultrasonic_pkg::*;
#(
  parameter int HALF_PERIOD = DEF_HALF_PERIOD,
  parameter int PULSE_COUNT = DEF_PULSE_COUNT,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  output logic tx_pulse,
  output logic done
);

  logic                 active;
  logic [CNT_WIDTH-1:0] half_cnt;
  logic [CNT_WIDTH-1:0] edge_cnt;
  logic                 half_last;
  logic                 edge_last;

  assign half_last = (half_cnt == CNT_WIDTH'(HALF_PERIOD - 1));
  assign edge_last = (edge_cnt == CNT_WIDTH'(2 * PULSE_COUNT - 1));
  assign done      = active & half_last & edge_last & ~abort;

  // Half-period and edge counters; abort wins over start and over a running burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active   <= 1'b0;
      tx_pulse <= 1'b0;
      half_cnt <= '0;
      edge_cnt <= '0;
    end else if (abort) begin
      active   <= 1'b0;
      tx_pulse <= 1'b0;
      half_cnt <= '0;
      edge_cnt <= '0;
    end else if (start) begin
      active   <= 1'b1;
      tx_pulse <= 1'b1;
      half_cnt <= '0;
      edge_cnt <= '0;
    end else if (active) begin
      if (half_last) begin
        half_cnt <= '0;
        if (edge_last) begin
          active   <= 1'b0;
          tx_pulse <= 1'b0;
          edge_cnt <= '0;
        end else begin
          edge_cnt <= edge_cnt + 1'b1;
          tx_pulse <= ~tx_pulse;
        end
      end else begin
        half_cnt <= half_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ultrasonic_ctrl.sv
// Command-execution stage behind the command decoder: owns power state,
// DAC amplitude, TX burst launch and the RX listening window.
//
// Command handshake: there is no ready. The decoder presents a word with
// valid; a word is taken exactly once, on the clock where valid rises
// (valid high now, low on the previous clock). Holding valid does not
// repeat the command. Words arriving in TX/RX are dropped, except off.
module ultrasonic_ctrl
  import ultrasonic_pkg::*;
#(
  parameter int AMOUNT_WIDTH = DEF_AMOUNT_WIDTH,
  parameter int DAC_WIDTH    = DEF_DAC_WIDTH,
  parameter int HALF_PERIOD  = DEF_HALF_PERIOD,
  parameter int PULSE_COUNT  = DEF_PULSE_COUNT,
  parameter int RX_WINDOW    = DEF_RX_WINDOW,
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    on,
  input  logic                    off,
  input  logic                    increase,
  input  logic                    decrease,
  input  logic                    send,
  input  logic                    receive,
  input  logic                    valid,
  input  logic [AMOUNT_WIDTH-1:0] amount,
  output logic [DAC_WIDTH-1:0]    dac_value,
  output logic                    dac_update,
  output logic                    tx_pulse,
  output logic                    rx_enable,
  output logic                    busy,
  output logic [1:0]              state
);

  logic                 valid_q;
  logic                 cmd_stb;
  logic [DAC_WIDTH-1:0] amp_reg;
  logic                 pend_rx;
  logic [CNT_WIDTH-1:0] rx_cnt;
  logic                 rx_last;

  logic [DAC_WIDTH-1:0] amt_ext;
  logic [DAC_WIDTH:0]   sum_ext;
  logic [DAC_WIDTH-1:0] amp_inc;
  logic [DAC_WIDTH-1:0] amp_dec;

  logic [1:0]           state_nx;
  logic [DAC_WIDTH-1:0] amp_nx;
  logic [DAC_WIDTH-1:0] dac_nx;
  logic                 pend_nx;
  logic                 burst_start;
  logic                 burst_abort;
  logic                 burst_done;

  assign cmd_stb = valid & ~valid_q;
  assign rx_last = (rx_cnt == CNT_WIDTH'(RX_WINDOW - 1));

  // Saturating add (one bit wider to see the carry) and clamped subtract.
  assign amt_ext = DAC_WIDTH'(amount);
  assign sum_ext = {1'b0, amp_reg} + {1'b0, amt_ext};
  assign amp_inc = sum_ext[DAC_WIDTH] ? '1 : sum_ext[DAC_WIDTH-1:0];
  assign amp_dec = (amt_ext > amp_reg) ? '0 : (amp_reg - amt_ext);

  burst_gen #(
    .HALF_PERIOD (HALF_PERIOD),
    .PULSE_COUNT (PULSE_COUNT),
    .CNT_WIDTH   (CNT_WIDTH)
  ) u_burst (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (burst_start),
    .abort    (burst_abort),
    .tx_pulse (tx_pulse),
    .done     (burst_done)
  );

  // Edge detector on valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= 1'b0;
    else        valid_q <= valid;
  end

  // Next-state, amplitude and burst control; off outranks everything.
  always_comb begin
    state_nx    = state;
    amp_nx      = amp_reg;
    dac_nx      = dac_value;
    pend_nx     = pend_rx;
    burst_start = 1'b0;
    burst_abort = 1'b0;
    if (cmd_stb && off) begin
      state_nx    = ST_OFF;
      dac_nx      = '0;
      pend_nx     = 1'b0;
      burst_abort = 1'b1;
    end else begin
      case (state)
        ST_OFF: begin
          if (cmd_stb && on) begin
            state_nx = ST_IDLE;
            dac_nx   = amp_reg;
          end
        end
        ST_IDLE: begin
          // on consumes the word; in IDLE it has nothing to do.
          if (cmd_stb && !on) begin
            if (increase && !decrease)      amp_nx = amp_inc;
            else if (decrease && !increase) amp_nx = amp_dec;
            dac_nx = amp_nx;
            if (send) begin
              state_nx    = ST_TX;
              pend_nx     = receive;
              burst_start = 1'b1;
            end else if (receive) begin
              state_nx = ST_RX;
            end
          end
        end
        ST_TX: begin
          if (burst_done) begin
            if (pend_rx) begin
              state_nx = ST_RX;
              pend_nx  = 1'b0;
            end else begin
              state_nx = ST_IDLE;
            end
          end
        end
        default: begin
          if (rx_last) state_nx = ST_IDLE;
        end
      endcase
    end
  end

  // State, amplitude and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_OFF;
      amp_reg    <= '0;
      dac_value  <= '0;
      dac_update <= 1'b0;
      pend_rx    <= 1'b0;
      rx_enable  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      amp_reg    <= amp_nx;
      dac_value  <= dac_nx;
      dac_update <= (dac_nx != dac_value);
      pend_rx    <= pend_nx;
      rx_enable  <= (state_nx == ST_RX);
      busy       <= is_busy(state_nx);
    end
  end

  // Listening-window counter, restarted on every RX entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt <= '0;
    end else if ((state == ST_RX) && (state_nx == ST_RX)) begin
      rx_cnt <= rx_cnt + 1'b1;
    end else begin
      rx_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_ultrasonic_ctrl.sv
// Bench for ultrasonic_ctrl: table of single-command vectors, hand
// sequences for burst/window timing and aborts, then random commands
// against a time-based reference model.
module tb_ultrasonic_ctrl;

  localparam int AW  = 8;
  localparam int DW  = 10;
  localparam int HP  = 25;
  localparam int PC  = 8;
  localparam int RW  = 2000;
  localparam int CW  = 16;
  localparam int MAXA = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          on, off, increase, decrease, send, receive, valid;
  logic [AW-1:0] amount;
  logic [DW-1:0] dac_value;
  logic          dac_update, tx_pulse, rx_enable, busy;
  logic [1:0]    state;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: mode plus elapsed clocks in the current TX/RX phase.
  int m_mode, m_amp, m_dac, m_el, m_pend;
  bit m_pv;
  logic [DW-1:0] exp_q[$];

  ultrasonic_ctrl #(
    .AMOUNT_WIDTH (AW), .DAC_WIDTH (DW), .HALF_PERIOD (HP),
    .PULSE_COUNT (PC), .RX_WINDOW (RW), .CNT_WIDTH (CW)
  ) dut (
    .clk (clk), .rst_n (rst_n), .on (on), .off (off),
    .increase (increase), .decrease (decrease), .send (send),
    .receive (receive), .valid (valid), .amount (amount),
    .dac_value (dac_value), .dac_update (dac_update),
    .tx_pulse (tx_pulse), .rx_enable (rx_enable), .busy (busy),
    .state (state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance the model for this edge, then compare all outputs.
  task automatic tick();
    bit stb;
    int old_dac;
    @(posedge clk);
    stb = valid && !m_pv;
    m_pv = valid;
    old_dac = m_dac;
    if (stb && off) begin
      m_mode = 0; m_dac = 0; m_pend = 0;
    end else if (m_mode == 2) begin
      m_el++;
      if (m_el == 2 * HP * PC) begin
        m_mode = m_pend ? 3 : 1;
        m_pend = 0;
        m_el = 0;
      end
    end else if (m_mode == 3) begin
      m_el++;
      if (m_el == RW) begin m_mode = 1; m_el = 0; end
    end else if (stb && m_mode == 0) begin
      if (on) begin m_mode = 1; m_dac = m_amp; end
    end else if (stb && m_mode == 1 && !on) begin
      if (increase && !decrease)
        m_amp = (m_amp + int'(amount) > MAXA) ? MAXA : m_amp + int'(amount);
      else if (decrease && !increase)
        m_amp = (int'(amount) > m_amp) ? 0 : m_amp - int'(amount);
      m_dac = m_amp;
      if (send) begin m_mode = 2; m_el = 0; m_pend = receive; end
      else if (receive) begin m_mode = 3; m_el = 0; end
    end
    if (m_dac != old_dac) exp_q.push_back(DW'(m_dac));
    #1;
    check("m_state", state, m_mode);
    check("m_dac", dac_value, m_dac);
    check("m_dac_update", dac_update, m_dac != old_dac);
    check("m_tx_pulse", tx_pulse, (m_mode == 2) && ((m_el / HP) % 2 == 0));
    check("m_rx_enable", rx_enable, m_mode == 3);
    check("m_busy", busy, m_mode >= 2);
    if (dac_update === 1'b1) begin
      if (exp_q.size() == 0) check("sb_extra_strobe", 1, 0);
      else check("sb_dac", dac_value, exp_q.pop_front());
    end
  endtask

  task automatic drive(input bit o, input bit f, input bit i, input bit d,
                       input bit s, input bit r, input int amt);
    on = o; off = f; increase = i; decrease = d; send = s; receive = r;
    amount = AW'(amt); valid = 1'b1;
  endtask

  task automatic release_cmd();
    valid = 1'b0; on = 0; off = 0; increase = 0; decrease = 0;
    send = 0; receive = 0; amount = '0;
  endtask

  typedef struct {
    bit on, off, inc, dec, snd, rcv;
    int amt;
    int e_state, e_dac, e_upd;
  } vec_t;

  vec_t vt[18];

  initial begin
    int cnt, tx_cyc, tx_hi, rises, rx_cyc, busy_cyc;
    bit prev_tx;

    // Reset
    rst_n = 1'b0;
    release_cmd();
    m_mode = 0; m_amp = 0; m_dac = 0; m_el = 0; m_pend = 0; m_pv = 0;
    #12;
    check("rst_state", state, 0);
    check("rst_dac", dac_value, 0);
    check("rst_flags", {dac_update, tx_pulse, rx_enable, busy}, 0);
    rst_n = 1'b1;

    //        on off inc dec snd rcv amt  state dac upd
    vt[0]  = '{1, 0, 0, 0, 0, 0, 0,   1, 0,    0};
    vt[1]  = '{0, 0, 1, 0, 0, 0, 200, 1, 200,  1};
    vt[2]  = '{0, 0, 1, 0, 0, 0, 200, 1, 400,  1};
    vt[3]  = '{0, 0, 1, 0, 0, 0, 200, 1, 600,  1};
    vt[4]  = '{0, 0, 1, 0, 0, 0, 255, 1, 855,  1};
    vt[5]  = '{0, 0, 1, 0, 0, 0, 255, 1, 1023, 1};
    vt[6]  = '{0, 0, 1, 0, 0, 0, 255, 1, 1023, 0};
    vt[7]  = '{0, 0, 0, 1, 0, 0, 255, 1, 768,  1};
    vt[8]  = '{0, 0, 0, 1, 0, 0, 255, 1, 513,  1};
    vt[9]  = '{0, 0, 0, 1, 0, 0, 255, 1, 258,  1};
    vt[10] = '{0, 0, 0, 1, 0, 0, 158, 1, 100,  1};
    vt[11] = '{0, 0, 0, 1, 0, 0, 255, 1, 0,    1};
    vt[12] = '{0, 0, 1, 1, 0, 0, 50,  1, 0,    0};
    vt[13] = '{0, 0, 1, 0, 0, 0, 40,  1, 40,   1};
    vt[14] = '{1, 0, 0, 0, 0, 0, 0,   1, 40,   0};
    vt[15] = '{0, 1, 0, 0, 0, 0, 0,   0, 0,    1};
    vt[16] = '{0, 0, 1, 0, 0, 0, 10,  0, 0,    0};
    vt[17] = '{1, 0, 0, 0, 0, 0, 0,   1, 40,   1};

    for (int k = 0; k < 18; k++) begin
      drive(vt[k].on, vt[k].off, vt[k].inc, vt[k].dec, vt[k].snd, vt[k].rcv, vt[k].amt);
      tick();
      check($sformatf("vec%0d_state", k), state, vt[k].e_state);
      check($sformatf("vec%0d_dac", k), dac_value, vt[k].e_dac);
      check($sformatf("vec%0d_upd", k), dac_update, vt[k].e_upd);
      release_cmd();
      tick();
    end

    // Held valid executes once
    drive(0, 0, 1, 0, 0, 0, 5);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (dac_update) cnt++;
    end
    release_cmd();
    tick();
    check("held_valid_dac", dac_value, 45);
    check("held_valid_strobes", cnt, 1);

    // Full burst followed by listen window
    drive(0, 0, 0, 0, 1, 1, 0);
    tick();
    release_cmd();
    check("burst_entry", {state, tx_pulse, busy}, {2'd2, 1'b1, 1'b1});
    tx_cyc = 0; tx_hi = 0; rises = 0; rx_cyc = 0; busy_cyc = 0; prev_tx = 0;
    for (int k = 0; k < 3000 && state != 2'd1; k++) begin
      if (state == 2'd2) tx_cyc++;
      if (tx_pulse) tx_hi++;
      if (tx_pulse && !prev_tx) rises++;
      if (rx_enable) rx_cyc++;
      if (busy) busy_cyc++;
      prev_tx = tx_pulse;
      tick();
    end
    check("burst_tx_cycles", tx_cyc, 2 * HP * PC);
    check("burst_tx_high", tx_hi, HP * PC);
    check("burst_periods", rises, PC);
    check("burst_rx_cycles", rx_cyc, RW);
    check("burst_busy_cycles", busy_cyc, 2 * HP * PC + RW);
    check("burst_end_state", state, 1);

    // off at clock 130 of a burst
    drive(0, 0, 0, 0, 1, 0, 0);
    tick();
    release_cmd();
    for (int k = 0; k < 128; k++) tick();
    drive(0, 1, 0, 0, 0, 0, 0);
    tick();
    check("abort_outputs", {state, tx_pulse, busy, rx_enable}, 0);
    check("abort_dac", dac_value, 0);
    release_cmd();
    tick();
    drive(1, 0, 0, 0, 0, 0, 0);
    tick();
    release_cmd();
    check("restore_dac", dac_value, 45);
    check("restore_state", state, 1);
    tick();

    // Commands ignored while busy
    drive(0, 0, 0, 0, 1, 1, 0);
    tick();
    release_cmd();
    for (int k = 0; k < 49; k++) tick();
    drive(0, 0, 1, 0, 0, 0, 20);
    tick();
    release_cmd();
    check("tx_ignore_inc_dac", dac_value, 45);
    check("tx_ignore_inc_state", state, 2);
    for (int k = 0; k < 500 && state != 2'd3; k++) tick();
    tick();
    drive(0, 0, 0, 0, 1, 0, 0);
    tick();
    release_cmd();
    check("rx_ignore_send", {state, tx_pulse}, {2'd3, 1'b0});
    for (int k = 0; k < 2100 && state != 2'd1; k++) tick();
    for (int k = 0; k < 30; k++) tick();
    check("no_new_burst", {state, busy, tx_pulse}, {2'd1, 1'b0, 1'b0});
    check("busy_end_dac", dac_value, 45);

    // Random commands against the model
    for (int k = 0; k < 6000; k++) begin
      valid    = ($urandom_range(0, 2) == 0);
      off      = ($urandom_range(0, 15) == 0);
      on       = ($urandom_range(0, 5) == 0);
      increase = $urandom_range(0, 1);
      decrease = $urandom_range(0, 1);
      send     = ($urandom_range(0, 9) == 0);
      receive  = ($urandom_range(0, 7) == 0);
      amount   = AW'($urandom_range(0, 255));
      tick();
    end
    release_cmd();
    tick();
    tick();

    check("sb_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
